// File: rtl/alu_issue_stage_if.sv
// Request, ALU-drive and response signals of the ALU issue stage, bundled with
// a slave view for the stage and a master view for its environment.
interface alu_issue_stage_if #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned TAGW  = 4,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_opcode;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [4:0]       req_shift;
  logic [TAGW-1:0]  req_tag;

  logic [3:0]       alu_opcode;
  logic [WIDTH-1:0] alu_input1;
  logic [WIDTH-1:0] alu_input2;
  logic [4:0]       alu_shift;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_zero;
  logic             alu_sign;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [2:0]       rsp_flags;
  logic [TAGW-1:0]  rsp_tag;
  logic             rsp_illegal;

  logic [LW-1:0]    level;

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, req_shift, req_tag,
    input  alu_result, alu_carry, alu_zero, alu_sign,
    input  rsp_ready,
    output req_ready,
    output alu_opcode, alu_input1, alu_input2, alu_shift,
    output rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_illegal,
    output level
  );

  modport master (
    output req_valid, req_opcode, req_a, req_b, req_shift, req_tag,
    output alu_result, alu_carry, alu_zero, alu_sign,
    output rsp_ready,
    input  req_ready,
    input  alu_opcode, alu_input1, alu_input2, alu_shift,
    input  rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_illegal,
    input  level
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue stage for the combinational ALU: request FIFO whose head drives the ALU,
// and a registered valid/ready response slot capturing the ALU result and flags.
module alu_issue_stage #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned TAGW  = 4,
  parameter int unsigned DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  alu_issue_stage_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] DepthLvl = LW'(DEPTH);

  logic [3:0]       op_mem  [DEPTH];
  logic [WIDTH-1:0] a_mem   [DEPTH];
  logic [WIDTH-1:0] b_mem   [DEPTH];
  logic [4:0]       sh_mem  [DEPTH];
  logic [TAGW-1:0]  tag_mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [2:0]       rsp_flags_q, rsp_flags_d;
  logic [TAGW-1:0]  rsp_tag_q, rsp_tag_d;
  logic             rsp_illegal_q, rsp_illegal_d;

  logic head_vld, req_ready, push, capture, head_illegal;

  // req_ready looks only at registered occupancy, so a full FIFO never
  // accepts a push in the same cycle that it pops.
  always_comb begin
    head_vld     = (level_q != '0);
    req_ready    = (level_q < DepthLvl);
    push         = bus.req_valid & req_ready;
    capture      = head_vld & (~rsp_valid_q | bus.rsp_ready);
    head_illegal = (op_mem[rd_ptr_q] > 4'd10);
  end

  always_comb begin
    bus.req_ready   = req_ready;
    bus.level       = level_q;
    bus.rsp_valid   = rsp_valid_q;
    bus.rsp_result  = rsp_result_q;
    bus.rsp_flags   = rsp_flags_q;
    bus.rsp_tag     = rsp_tag_q;
    bus.rsp_illegal = rsp_illegal_q;
    bus.alu_opcode  = '0;
    bus.alu_input1  = '0;
    bus.alu_input2  = '0;
    bus.alu_shift   = '0;
    if (head_vld) begin
      bus.alu_opcode = op_mem[rd_ptr_q];
      bus.alu_input1 = a_mem[rd_ptr_q];
      bus.alu_input2 = b_mem[rd_ptr_q];
      bus.alu_shift  = sh_mem[rd_ptr_q];
    end
  end

  always_comb begin
    wr_ptr_d = push    ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = capture ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, capture})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_illegal_d = rsp_illegal_q;
    if (capture) begin
      rsp_valid_d   = 1'b1;
      rsp_tag_d     = tag_mem[rd_ptr_q];
      rsp_illegal_d = head_illegal;
      if (head_illegal) begin
        // Undefined opcodes never reach a real ALU result: report zero.
        rsp_result_d = '0;
        rsp_flags_d  = 3'b010;
      end else begin
        rsp_result_d = bus.alu_result;
        rsp_flags_d  = {bus.alu_carry, bus.alu_zero, bus.alu_sign};
      end
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_q]  <= bus.req_opcode;
      a_mem[wr_ptr_q]   <= bus.req_a;
      b_mem[wr_ptr_q]   <= bus.req_b;
      sh_mem[wr_ptr_q]  <= bus.req_shift;
      tag_mem[wr_ptr_q] <= bus.req_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= '0;
      rsp_tag_q     <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end
endmodule
